// File: rtl/mem_issue_queue.sv
// Load/store issue buffer in front of the single-port miss-path data memory.
// Operations wait in a small FIFO and are handed to memory one at a time.
module mem_issue_queue #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_addr,
    input  logic [5:0]  in_reg,
    input  logic [3:0]  in_optype,
    input  logic [31:0] in_data,
    output logic [31:0] mem_pc,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_data,
    output logic [5:0]  mem_reg,
    output logic [3:0]  mem_optype,
    output logic        mem_read_en,
    output logic        mem_write_en,
    output logic        mem_cache_miss,
    input  logic [31:0] mem_lw_data,
    input  logic        mem_data_valid,
    input  logic        mem_has_stored,
    output logic        wb_valid,
    output logic [31:0] wb_pc,
    output logic [5:0]  wb_reg,
    output logic [31:0] wb_data,
    output logic        st_done,
    output logic        busy,
    output logic        err_timeout
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [3:0] OP_LB = 4'd7;
    localparam logic [3:0] OP_LW = 4'd8;
    localparam logic [3:0] OP_SB = 4'd9;
    localparam logic [3:0] OP_SW = 4'd10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [TW-1:0] cnt_q, cnt_d;

    logic [31:0] pc_q   [DEPTH];
    logic [31:0] addr_q [DEPTH];
    logic [31:0] data_q [DEPTH];
    logic [5:0]  reg_q  [DEPTH];
    logic [3:0]  op_q   [DEPTH];

    logic        wb_valid_q, st_done_q, err_q;
    logic [31:0] wb_pc_q, wb_data_q;
    logic [5:0]  wb_reg_q;

    logic legal_s, push_s, pop_s, head_load_s;
    logic resp_ld_s, resp_st_s, tmo_s;

    assign legal_s     = (in_optype == OP_LB) || (in_optype == OP_LW) ||
                         (in_optype == OP_SB) || (in_optype == OP_SW);
    assign in_ready    = (count_q < CW'(DEPTH));
    assign push_s      = in_valid && in_ready && legal_s;
    assign head_load_s = (op_q[head_q] == OP_LB) || (op_q[head_q] == OP_LW);

    // A response of the wrong kind for the head is ignored; a response beats a timeout.
    assign resp_ld_s = (state_q == S_WAIT) && head_load_s && mem_data_valid;
    assign resp_st_s = (state_q == S_WAIT) && !head_load_s && mem_has_stored;
    assign tmo_s     = (state_q == S_WAIT) && !resp_ld_s && !resp_st_s &&
                       (cnt_q == TW'(TIMEOUT - 1));
    assign pop_s     = resp_ld_s || resp_st_s || tmo_s;

    assign busy = (state_q != S_IDLE) || (count_q != {CW{1'b0}});

    // State, pointers, occupancy and wait counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            head_q  <= {PW{1'b0}};
            tail_q  <= {PW{1'b0}};
            count_q <= {CW{1'b0}};
            cnt_q   <= {TW{1'b0}};
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            cnt_q   <= cnt_d;
        end
    end

    // Entry storage, written at the tail on accept.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]   <= 32'd0;
                addr_q[i] <= 32'd0;
                data_q[i] <= 32'd0;
                reg_q[i]  <= 6'd0;
                op_q[i]   <= 4'd0;
            end
        end else if (push_s) begin
            pc_q[tail_q]   <= in_pc;
            addr_q[tail_q] <= in_addr;
            data_q[tail_q] <= in_data;
            reg_q[tail_q]  <= in_reg;
            op_q[tail_q]   <= in_optype;
        end
    end

    // Next-state logic of the issue FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (count_q != {CW{1'b0}}) state_d = S_ISSUE;
                else                       state_d = S_IDLE;
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (pop_s) state_d = S_IDLE;
                else       state_d = S_WAIT;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Pointer, occupancy and wait-counter updates.
    always_comb begin
        head_d  = pop_s  ? head_q + PW'(1) : head_q;
        tail_d  = push_s ? tail_q + PW'(1) : tail_q;
        count_d = count_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        case (state_q)
            S_WAIT:  cnt_d = cnt_q + TW'(1);
            default: cnt_d = {TW{1'b0}};
        endcase
    end

    // Memory-side outputs decoded from the registered state and head entry.
    always_comb begin
        mem_pc         = 32'd0;
        mem_addr       = 32'd0;
        mem_data       = 32'd0;
        mem_reg        = 6'd0;
        mem_optype     = 4'd0;
        mem_read_en    = 1'b0;
        mem_write_en   = 1'b0;
        mem_cache_miss = 1'b0;
        if (state_q != S_IDLE) begin
            mem_pc         = pc_q[head_q];
            mem_addr       = addr_q[head_q];
            mem_data       = data_q[head_q];
            mem_reg        = reg_q[head_q];
            mem_cache_miss = 1'b1;
            mem_optype     = (state_q == S_ISSUE) ? op_q[head_q] : 4'd0;
            mem_write_en   = (state_q == S_ISSUE) && !head_load_s;
            mem_read_en    = (state_q == S_WAIT) && head_load_s;
        end else begin
            mem_cache_miss = 1'b0;
        end
    end

    // Writeback outputs, registered one cycle after the response is sampled.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wb_valid_q <= 1'b0;
            st_done_q  <= 1'b0;
            err_q      <= 1'b0;
            wb_pc_q    <= 32'd0;
            wb_data_q  <= 32'd0;
            wb_reg_q   <= 6'd0;
        end else begin
            wb_valid_q <= resp_ld_s;
            st_done_q  <= resp_st_s;
            err_q      <= err_q | tmo_s;
            if (resp_ld_s || resp_st_s) wb_pc_q <= pc_q[head_q];
            if (resp_ld_s) begin
                wb_data_q <= mem_lw_data;
                wb_reg_q  <= reg_q[head_q];
            end
        end
    end

    assign wb_valid    = wb_valid_q;
    assign st_done     = st_done_q;
    assign wb_pc       = wb_pc_q;
    assign wb_reg      = wb_reg_q;
    assign wb_data     = wb_data_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_mem_issue_queue.sv
// Self-checking bench for mem_issue_queue: vector table plus hand-written
// sequences, with a memory model and an in-order writeback scoreboard.
module tb_mem_issue_queue;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rstn;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_pc = 32'd0, in_addr = 32'd0, in_data = 32'd0;
    logic [5:0]  in_reg = 6'd0;
    logic [3:0]  in_optype = 4'd0;
    logic [31:0] mem_pc, mem_addr, mem_data;
    logic [5:0]  mem_reg;
    logic [3:0]  mem_optype;
    logic        mem_read_en, mem_write_en, mem_cache_miss;
    logic [31:0] mem_lw_data = 32'd0;
    logic        mem_data_valid = 1'b0, mem_has_stored = 1'b0;
    logic        wb_valid, st_done, busy, err_timeout;
    logic [31:0] wb_pc, wb_data;
    logic [5:0]  wb_reg;

    always #5 clk = ~clk;

    mem_issue_queue #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_addr(in_addr),
        .in_reg(in_reg), .in_optype(in_optype), .in_data(in_data),
        .mem_pc(mem_pc), .mem_addr(mem_addr), .mem_data(mem_data), .mem_reg(mem_reg),
        .mem_optype(mem_optype), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
        .mem_cache_miss(mem_cache_miss), .mem_lw_data(mem_lw_data),
        .mem_data_valid(mem_data_valid), .mem_has_stored(mem_has_stored),
        .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_reg(wb_reg), .wb_data(wb_data),
        .st_done(st_done), .busy(busy), .err_timeout(err_timeout)
    );

    typedef struct {
        logic [3:0]  op;
        logic [31:0] pc;
        logic [31:0] addr;
        logic [5:0]  rg;
        logic [31:0] data;
        bit          legal;
    } vec_t;

    typedef struct {
        bit          is_load;
        logic [31:0] pc;
        logic [5:0]  rg;
        logic [31:0] data;
    } exp_t;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    exp_t        sb_q[$];
    int          issue_cyc[$];
    int          last_issue = 0;
    int          drops_req = 0, drops_done = 0;
    int          cd = 0;
    bit          p_load = 1'b0;
    int          p_idx = 0;
    logic [31:0] mdl_mem[int];
    logic [31:0] exp_mem[int];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] dflt(input int a);
        return (a == 5) ? 32'hDEADBEEF : (32'hA5A50000 | 32'(a));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Memory model: responds 11 cycles after ISSUE unless told to drop the next op.
    always @(negedge clk) begin
        mem_data_valid = 1'b0;
        mem_has_stored = 1'b0;
        if (mem_cache_miss && mem_optype != 4'd0) begin
            issue_cyc.push_back(cyc);
            last_issue = cyc;
            if (mem_write_en) mdl_mem[int'(mem_addr[5:0])] = mem_data;
            if (drops_req != drops_done) begin
                drops_done++;
            end else begin
                cd     = 11;
                p_load = (mem_optype == 4'd7) || (mem_optype == 4'd8);
                p_idx  = int'(mem_addr[5:0]);
            end
        end else if (cd > 0) begin
            cd--;
            if (cd == 0) begin
                if (p_load) begin
                    mem_lw_data    = mdl_mem.exists(p_idx) ? mdl_mem[p_idx] : dflt(p_idx);
                    mem_data_valid = 1'b1;
                end else begin
                    mem_has_stored = 1'b1;
                end
            end
        end
    end

    // Writeback monitor: every pulse must match the oldest expected completion.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (wb_valid || st_done) begin
            if (sb_q.size() == 0) begin
                check("wb_unexpected", {30'd0, wb_valid, st_done}, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("wb_kind", {30'd0, wb_valid, st_done}, e.is_load ? 32'd2 : 32'd1);
                check("wb_pc", wb_pc, e.pc);
                check("wb_latency", 32'(cyc - last_issue), 32'd12);
                if (e.is_load) begin
                    check("wb_reg", {26'd0, wb_reg}, {26'd0, e.rg});
                    check("wb_data", wb_data, e.data);
                end
            end
        end
    end

    task automatic offer(input logic [3:0] op, input logic [31:0] pc, input logic [31:0] addr,
                         input logic [5:0] rg, input logic [31:0] data, input bit expect_out,
                         output int waited);
        exp_t e;
        int   a;
        in_valid  = 1'b1;
        in_optype = op;
        in_pc     = pc;
        in_addr   = addr;
        in_reg    = rg;
        in_data   = data;
        waited    = 0;
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check("offer_ready", 32'(in_ready), 32'd1);
        a = int'(addr[5:0]);
        if (in_ready && expect_out && op >= 4'd7 && op <= 4'd10) begin
            e.is_load = (op == 4'd7) || (op == 4'd8);
            e.pc      = pc;
            e.rg      = rg;
            e.data    = 32'd0;
            if (e.is_load) e.data = exp_mem.exists(a) ? exp_mem[a] : dflt(a);
            else           exp_mem[a] = data;
            sb_q.push_back(e);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        in_optype = 4'd0;
    endtask

    task automatic wait_idle(input string name, input int max);
        int w = 0;
        while ((busy || cd > 0) && w < max) begin
            @(negedge clk);
            w++;
        end
        check({"idle_", name}, 32'(busy), 32'd0);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_err"}, 32'(err_timeout), 32'd0);
        check({tag, "_wb"}, {29'd0, wb_valid, st_done, mem_cache_miss}, 32'd0);
        check({tag, "_wb_fields"}, wb_pc | wb_data | {26'd0, wb_reg}, 32'd0);
        check({tag, "_mem_ctl"}, {26'd0, mem_optype, mem_read_en, mem_write_en}, 32'd0);
        check({tag, "_mem_fields"}, mem_pc | mem_addr | mem_data | {26'd0, mem_reg}, 32'd0);
    endtask

    initial begin
        vec_t vt[9];
        int   w;
        int   bw[6];
        int   k;
        bit   is_ld, is_st;

        vt[0] = '{4'd8,  32'h40, 32'd5, 6'd12, 32'd0,       1'b1};
        vt[1] = '{4'd3,  32'h60, 32'd5, 6'd1,  32'd0,       1'b0};
        vt[2] = '{4'd10, 32'h44, 32'd3, 6'd0,  32'h1234,    1'b1};
        vt[3] = '{4'd8,  32'h48, 32'd3, 6'd7,  32'd0,       1'b1};
        vt[4] = '{4'd9,  32'h4C, 32'd9, 6'd0,  32'h000000FF, 1'b1};
        vt[5] = '{4'd7,  32'h50, 32'd9, 6'd33, 32'd0,       1'b1};
        vt[6] = '{4'd0,  32'h64, 32'd1, 6'd2,  32'd0,       1'b0};
        vt[7] = '{4'd11, 32'h68, 32'd1, 6'd2,  32'd0,       1'b0};
        vt[8] = '{4'd15, 32'h6C, 32'd1, 6'd2,  32'd0,       1'b0};

        rstn = 1'b1;
        #2 rstn = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("init");
        rstn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            is_ld = vt[i].legal && (vt[i].op == 4'd7 || vt[i].op == 4'd8);
            is_st = vt[i].legal && (vt[i].op == 4'd9 || vt[i].op == 4'd10);
            offer(vt[i].op, vt[i].pc, vt[i].addr, vt[i].rg, vt[i].data, vt[i].legal, w);
            check($sformatf("v%0d_pre_issue", i), {28'd0, mem_optype}, 32'd0);
            check($sformatf("v%0d_busy", i), 32'(busy), 32'(vt[i].legal));
            @(negedge clk);
            check($sformatf("v%0d_issue_op", i), {28'd0, mem_optype},
                  vt[i].legal ? {28'd0, vt[i].op} : 32'd0);
            check($sformatf("v%0d_wen", i), 32'(mem_write_en), 32'(is_st));
            check($sformatf("v%0d_miss", i), 32'(mem_cache_miss), 32'(vt[i].legal));
            @(negedge clk);
            check($sformatf("v%0d_ren", i), 32'(mem_read_en), 32'(is_ld));
            wait_idle($sformatf("v%0d", i), 40);
        end

        // Store then load to the same word, offered back to back.
        issue_cyc.delete();
        offer(4'd10, 32'h80, 32'd20, 6'd0, 32'hCAFE0001, 1'b1, w);
        offer(4'd8,  32'h84, 32'd20, 6'd3, 32'd0,        1'b1, w);
        wait_idle("sw_lw", 60);
        check("sw_lw_issues", 32'(issue_cyc.size()), 32'd2);
        if (issue_cyc.size() == 2)
            check("sw_lw_spacing", 32'(issue_cyc[1] - issue_cyc[0]), 32'd13);

        // Six loads into a four-entry FIFO.
        issue_cyc.delete();
        for (int i = 0; i < 6; i++) begin
            offer(4'd8, 32'h100 + 32'(4 * i), 32'(40 + i), 6'(i + 1), 32'd0, 1'b1, bw[i]);
            if (i == 3) check("bp_ready_low", 32'(in_ready), 32'd0);
        end
        check("bp_op4_nowait", 32'(bw[3]), 32'd0);
        check("bp_op5_waited", 32'(bw[4] > 0), 32'd1);
        wait_idle("bp", 200);
        check("bp_issues", 32'(issue_cyc.size()), 32'd6);
        if (issue_cyc.size() == 6)
            for (int j = 1; j < 6; j++)
                check($sformatf("bp_spacing%0d", j), 32'(issue_cyc[j] - issue_cyc[j-1]), 32'd13);

        // Timeout: memory never answers the first load; the second still completes.
        issue_cyc.delete();
        drops_req++;
        offer(4'd8, 32'h200, 32'd7, 6'd1, 32'd0, 1'b0, w);
        offer(4'd8, 32'h204, 32'd5, 6'd2, 32'd0, 1'b1, w);
        w = 0;
        while (issue_cyc.size() == 0 && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("tmo_first_issue", 32'(issue_cyc.size() > 0), 32'd1);
        k = (issue_cyc.size() > 0) ? issue_cyc[0] : cyc;
        while (cyc < k + 16) @(negedge clk);
        check("tmo_err_before", 32'(err_timeout), 32'd0);
        check("tmo_still_wait", 32'(mem_read_en), 32'd1);
        @(negedge clk);
        check("tmo_err_set", 32'(err_timeout), 32'd1);
        check("tmo_idle", 32'(mem_cache_miss), 32'd0);
        @(negedge clk);
        check("tmo_next_issue", {28'd0, mem_optype}, 32'd8);
        wait_idle("tmo", 60);
        check("tmo_sticky", 32'(err_timeout), 32'd1);
        check("tmo_issues", 32'(issue_cyc.size()), 32'd2);
        if (issue_cyc.size() == 2)
            check("tmo_spacing", 32'(issue_cyc[1] - issue_cyc[0]), 32'd18);

        // Reset in the middle of WAIT; the late response must be ignored.
        offer(4'd8, 32'h300, 32'd5, 6'd9, 32'd0, 1'b0, w);
        w = 0;
        while (!mem_read_en && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("rst_in_wait", 32'(mem_read_en), 32'd1);
        repeat (2) @(negedge clk);
        rstn = 1'b0;
        #1;
        check("rst_async_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check_reset("midwait");
        rstn = 1'b1;
        repeat (15) @(negedge clk);
        check("rst_after_busy", 32'(busy), 32'd0);
        check("rst_after_miss", 32'(mem_cache_miss), 32'd0);
        check("rst_model_done", 32'(cd), 32'd0);

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
